tiny_rv_hazard_ctrl: RTL and testbench

TINY_RV_HAZARD_CTRL -- requirements
Module: tiny_rv_hazard_ctrl

---
 rtl/tiny_rv_hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_tiny_rv_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_rv_hazard_ctrl.sv
// rtl/tiny_rv_hazard_ctrl.sv - pipeline hazard/redirect controller; optional forwarding via TINY_RV_HAZARD_FWD_EN
module tiny_rv_hazard_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dec_valid,
  input  logic [4:0]  i_dec_rs1,
  input  logic [4:0]  i_dec_rs2,
  input  logic        i_dec_use_rs1,
  input  logic        i_dec_use_rs2,
  input  logic        i_ex_valid,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_is_load,
  input  logic [31:0] i_ex_result,
  input  logic        i_mem_valid,
  input  logic [4:0]  i_mem_rd,
  input  logic [31:0] i_mem_result,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_mem_busy,
  output logic        o_pipe_stall,
  output logic        o_pipe_flush,
  output logic        o_ld_new_pc,
  output logic [31:0] o_new_pc,
  output logic [4:0]  o_of1_reg,
  output logic [4:0]  o_of2_reg,
  output logic [31:0] o_of1_val,
  output logic [31:0] o_of2_val,
  output logic [15:0] o_stall_cnt
);

  typedef enum logic [1:0] {RUN, REDIR, FLUSH, MEMWAIT} state_t;

  state_t      state, state_nxt;
  logic        pend, pend_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic [31:0] new_pc, new_pc_nxt;
  logic [15:0] stall_cnt;
  logic        dep_stall;
  logic        ex_hit;

  // A producer only matters if it writes a non-zero register that decode actually reads
  assign ex_hit = i_ex_valid && (i_ex_rd != 5'd0) &&
                  ((i_dec_use_rs1 && (i_dec_rs1 == i_ex_rd)) ||
                   (i_dec_use_rs2 && (i_dec_rs2 == i_ex_rd)));

`ifdef TINY_RV_HAZARD_FWD_EN
  logic unused_wb;
  assign unused_wb = ^{i_wb_valid, i_wb_rd};

  // Only a load in execute cannot be bypassed; everything else is forwarded
  assign dep_stall = i_dec_valid && i_ex_is_load && ex_hit;

  // Operand bypass: youngest producer (execute, non-load) beats memory; x0 never forwarded
  always_comb begin
    o_of1_reg = 5'd0;
    o_of1_val = 32'd0;
    o_of2_reg = 5'd0;
    o_of2_val = 32'd0;
    if (!i_reset) begin
      if (i_dec_rs1 != 5'd0) begin
        if (i_ex_valid && !i_ex_is_load && (i_ex_rd == i_dec_rs1)) begin
          o_of1_reg = i_dec_rs1;
          o_of1_val = i_ex_result;
        end else if (i_mem_valid && (i_mem_rd == i_dec_rs1)) begin
          o_of1_reg = i_dec_rs1;
          o_of1_val = i_mem_result;
        end
      end
      if (i_dec_rs2 != 5'd0) begin
        if (i_ex_valid && !i_ex_is_load && (i_ex_rd == i_dec_rs2)) begin
          o_of2_reg = i_dec_rs2;
          o_of2_val = i_ex_result;
        end else if (i_mem_valid && (i_mem_rd == i_dec_rs2)) begin
          o_of2_reg = i_dec_rs2;
          o_of2_val = i_mem_result;
        end
      end
    end
  end
`else
  logic mem_hit, wb_hit;
  logic unused_fwd;
  assign unused_fwd = ^{i_ex_is_load, i_ex_result, i_mem_result};

  assign mem_hit = i_mem_valid && (i_mem_rd != 5'd0) &&
                   ((i_dec_use_rs1 && (i_dec_rs1 == i_mem_rd)) ||
                    (i_dec_use_rs2 && (i_dec_rs2 == i_mem_rd)));
  assign wb_hit  = i_wb_valid && (i_wb_rd != 5'd0) &&
                   ((i_dec_use_rs1 && (i_dec_rs1 == i_wb_rd)) ||
                    (i_dec_use_rs2 && (i_dec_rs2 == i_wb_rd)));

  // Without bypass paths any in-flight writer of a used source holds decode
  assign dep_stall = i_dec_valid && (ex_hit || mem_hit || wb_hit);

  // No bypass network in this build
  always_comb begin
    o_of1_reg = 5'd0;
    o_of1_val = 32'd0;
    o_of2_reg = 5'd0;
    o_of2_val = 32'd0;
  end
`endif

  // Next-state and output decode; flush states never stall
  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend;
    pend_pc_nxt  = pend_pc;
    new_pc_nxt   = new_pc;
    o_pipe_stall = 1'b0;
    o_pipe_flush = 1'b0;
    o_ld_new_pc  = 1'b0;
    case (state)
      RUN: begin
        o_pipe_stall = i_mem_busy || dep_stall;
        if (i_mem_busy) begin
          state_nxt = MEMWAIT;
          if (i_redirect) begin
            pend_nxt    = 1'b1;
            pend_pc_nxt = i_redirect_pc;
          end
        end else if (i_redirect) begin
          state_nxt  = REDIR;
          new_pc_nxt = i_redirect_pc;
        end
      end
      REDIR: begin
        o_pipe_flush = 1'b1;
        o_ld_new_pc  = 1'b1;
        state_nxt    = FLUSH;
      end
      FLUSH: begin
        o_pipe_flush = 1'b1;
        state_nxt    = RUN;
      end
      MEMWAIT: begin
        o_pipe_stall = i_mem_busy;
        if (i_redirect) begin
          pend_nxt    = 1'b1;
          pend_pc_nxt = i_redirect_pc;
        end
        if (!i_mem_busy) begin
          if (i_redirect) begin
            state_nxt  = REDIR;
            new_pc_nxt = i_redirect_pc;
            pend_nxt   = 1'b0;
          end else if (pend) begin
            state_nxt  = REDIR;
            new_pc_nxt = pend_pc;
            pend_nxt   = 1'b0;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
    if (i_reset) begin
      o_pipe_stall = 1'b0;
      o_pipe_flush = 1'b0;
      o_ld_new_pc  = 1'b0;
    end
  end

  // State, pending redirect and target PC registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= RUN;
      pend    <= 1'b0;
      pend_pc <= 32'd0;
      new_pc  <= 32'd0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      pend_pc <= pend_pc_nxt;
      new_pc  <= new_pc_nxt;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt <= 16'd0;
    end else if (o_pipe_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign o_new_pc    = new_pc;
  assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_tiny_rv_hazard_ctrl.sv
// tb/tb_tiny_rv_hazard_ctrl.sv - self-checking bench for tiny_rv_hazard_ctrl
module tb_tiny_rv_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, dec_valid, use_rs1, use_rs2, ex_valid, ex_is_load;
  logic        mem_valid, wb_valid, redirect, mem_busy;
  logic [4:0]  rs1, rs2, ex_rd, mem_rd, wb_rd;
  logic [31:0] ex_result, mem_result, redirect_pc;
  logic        pipe_stall, pipe_flush, ld_new_pc;
  logic [31:0] new_pc, of1_val, of2_val;
  logic [4:0]  of1_reg, of2_reg;
  logic [15:0] stall_cnt;

  tiny_rv_hazard_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_dec_valid(dec_valid),
    .i_dec_rs1(rs1), .i_dec_rs2(rs2), .i_dec_use_rs1(use_rs1), .i_dec_use_rs2(use_rs2),
    .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load), .i_ex_result(ex_result),
    .i_mem_valid(mem_valid), .i_mem_rd(mem_rd), .i_mem_result(mem_result),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .i_mem_busy(mem_busy),
    .o_pipe_stall(pipe_stall), .o_pipe_flush(pipe_flush), .o_ld_new_pc(ld_new_pc),
    .o_new_pc(new_pc), .o_of1_reg(of1_reg), .o_of2_reg(of2_reg),
    .o_of1_val(of1_val), .o_of2_val(of2_val), .o_stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // reference model state: cycles of flush still owed, memory-wait flag, pending redirect
  int          flush_left = 0;
  bit          waiting = 0;
  bit          have_pend = 0;
  logic [31:0] pend_pc = 0;
  logic [31:0] exp_pc = 0;
  int          exp_cnt = 0;

  typedef struct {
    logic dv; logic [4:0] r1; logic [4:0] r2; logic u1; logic u2;
    logic exv; logic [4:0] exrd; logic ld; logic [31:0] exres;
    logic mv; logic [4:0] mrd; logic [31:0] mres;
    logic wv; logic [4:0] wrd;
    logic st_fwd; logic st_nofwd;
    logic [4:0] f1r; logic [31:0] f1v; logic [4:0] f2r; logic [31:0] f2v;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 0; dec_valid = 0; rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_result = 0;
    mem_valid = 0; mem_rd = 0; mem_result = 0; wb_valid = 0; wb_rd = 0;
    redirect = 0; redirect_pc = 0; mem_busy = 0;
  endtask

  function automatic void fwd_of(input logic [4:0] rs, output logic [4:0] r, output logic [31:0] v);
    r = 0; v = 0;
`ifdef TINY_RV_HAZARD_FWD_EN
    if (rs != 0) begin
      if (ex_valid && !ex_is_load && ex_rd == rs) begin r = rs; v = ex_result; end
      else if (mem_valid && mem_rd == rs) begin r = rs; v = mem_result; end
    end
`endif
  endfunction

  function automatic bit dep_stall();
    logic [4:0] srcs[$];
    logic [4:0] prod[$];
    if (!dec_valid) return 0;
    if (use_rs1 && rs1 != 0) srcs.push_back(rs1);
    if (use_rs2 && rs2 != 0) srcs.push_back(rs2);
`ifdef TINY_RV_HAZARD_FWD_EN
    if (ex_valid && ex_is_load) prod.push_back(ex_rd);
`else
    if (ex_valid) prod.push_back(ex_rd);
    if (mem_valid) prod.push_back(mem_rd);
    if (wb_valid) prod.push_back(wb_rd);
`endif
    foreach (srcs[i]) foreach (prod[j]) if (srcs[i] == prod[j]) return 1;
    return 0;
  endfunction

  // check all outputs against the model, then advance the model across the clock edge
  task automatic cycle();
    logic es, ef, el;
    logic [4:0] r1, r2;
    logic [31:0] v1, v2;
    #1;
    fwd_of(rs1, r1, v1);
    fwd_of(rs2, r2, v2);
    if (reset) begin
      es = 0; ef = 0; el = 0; r1 = 0; r2 = 0; v1 = 0; v2 = 0;
    end else begin
      ef = flush_left > 0;
      el = flush_left == 2;
      es = !ef && (mem_busy || (!waiting && dep_stall()));
    end
    chk("m_stall", pipe_stall, es);
    chk("m_flush", pipe_flush, ef);
    chk("m_ld_new_pc", ld_new_pc, el);
    if (el) chk("m_new_pc", new_pc, exp_pc);
    chk("m_of1_reg", of1_reg, r1);
    chk("m_of1_val", of1_val, v1);
    chk("m_of2_reg", of2_reg, r2);
    chk("m_of2_val", of2_val, v2);
    chk("m_stall_cnt", stall_cnt, exp_cnt);
    @(posedge clk);
    if (reset) begin
      flush_left = 0; waiting = 0; have_pend = 0; exp_pc = 0; exp_cnt = 0;
    end else begin
      if (es && exp_cnt < 65535) exp_cnt++;
      if (flush_left > 0) flush_left--;
      else if (waiting || mem_busy) begin
        if (redirect) begin have_pend = 1; pend_pc = redirect_pc; end
        if (waiting && !mem_busy) begin
          waiting = 0;
          if (have_pend) begin flush_left = 2; exp_pc = pend_pc; have_pend = 0; end
        end else waiting = 1;
      end else if (redirect) begin
        flush_left = 2; exp_pc = redirect_pc;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1,5,0,1,0, 1,5,1,32'hDEAD_BEEF, 0,0,0, 0,0, 1,1, 0,0,0,0};
    vecs[1] = '{1,0,0,1,0, 1,0,1,32'h1111, 0,0,0, 0,0, 0,0, 0,0,0,0};
    vecs[2] = '{1,3,0,1,0, 1,3,0,32'hAAAA_0000, 1,3,32'h1234, 0,0, 0,1, 3,32'hAAAA_0000,0,0};
    vecs[3] = '{1,1,9,0,1, 1,1,0,32'h77, 1,9,32'h55, 0,0, 0,1, 1,32'h77,9,32'h55};
    vecs[4] = '{1,0,7,0,1, 0,0,0,0, 0,0,0, 1,7, 0,1, 0,0,0,0};
    vecs[5] = '{0,4,0,1,0, 1,4,1,32'h44, 0,0,0, 0,0, 0,0, 0,0,0,0};
    vecs[6] = '{1,6,0,0,0, 1,6,1,32'h66, 0,0,0, 0,0, 0,0, 0,0,0,0};
    vecs[7] = '{1,2,0,1,0, 0,2,0,32'h22, 1,2,32'hBEEF, 0,0, 0,1, 2,32'hBEEF,0,0};

    idle();
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    cycle();
    reset = 0;
    #1;
    chk("reset_flush", pipe_flush, 0);
    chk("reset_ld", ld_new_pc, 0);
    chk("reset_new_pc", new_pc, 0);
    chk("reset_cnt", stall_cnt, 0);
    cycle();

    for (int i = 0; i < 8; i++) begin
      idle();
      dec_valid = vecs[i].dv; rs1 = vecs[i].r1; rs2 = vecs[i].r2;
      use_rs1 = vecs[i].u1; use_rs2 = vecs[i].u2;
      ex_valid = vecs[i].exv; ex_rd = vecs[i].exrd; ex_is_load = vecs[i].ld; ex_result = vecs[i].exres;
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_result = vecs[i].mres;
      wb_valid = vecs[i].wv; wb_rd = vecs[i].wrd;
      #1;
`ifdef TINY_RV_HAZARD_FWD_EN
      chk($sformatf("vec%0d_stall", i), pipe_stall, vecs[i].st_fwd);
      chk($sformatf("vec%0d_of1_reg", i), of1_reg, vecs[i].f1r);
      chk($sformatf("vec%0d_of1_val", i), of1_val, vecs[i].f1v);
      chk($sformatf("vec%0d_of2_reg", i), of2_reg, vecs[i].f2r);
      chk($sformatf("vec%0d_of2_val", i), of2_val, vecs[i].f2v);
`else
      chk($sformatf("vec%0d_stall", i), pipe_stall, vecs[i].st_nofwd);
      chk($sformatf("vec%0d_of1_reg", i), of1_reg, 0);
      chk($sformatf("vec%0d_of2_val", i), of2_val, 0);
`endif
      cycle();
    end

    idle();
    redirect = 1; redirect_pc = 32'h0000_0100;
    cycle();
    idle();
    #1;
    chk("redir_ld", ld_new_pc, 1);
    chk("redir_pc", new_pc, 32'h100);
    chk("redir_flush", pipe_flush, 1);
    redirect = 1; redirect_pc = 32'hBAD0;
    cycle();
    #1;
    chk("flush_ld", ld_new_pc, 0);
    chk("flush_flush", pipe_flush, 1);
    cycle();
    idle();
    #1;
    chk("run_flush", pipe_flush, 0);
    chk("run_ld", ld_new_pc, 0);
    cycle();
    cycle();

    for (int c = 1; c <= 4; c++) begin
      idle();
      mem_busy = 1;
      if (c == 2) begin redirect = 1; redirect_pc = 32'h200; end
      #1;
      chk($sformatf("busy%0d_stall", c), pipe_stall, 1);
      cycle();
    end
    idle();
    #1;
    chk("busy_done_stall", pipe_stall, 0);
    chk("busy_done_ld", ld_new_pc, 0);
    cycle();
    #1;
    chk("memredir_ld", ld_new_pc, 1);
    chk("memredir_pc", new_pc, 32'h200);
    cycle();
    cycle();

    for (int k = 0; k < 3000; k++) begin
      idle();
      reset = ($urandom_range(0, 49) == 0);
      dec_valid = $urandom_range(0, 3) != 0;
      rs1 = $urandom_range(0, 3); rs2 = $urandom_range(0, 3);
      use_rs1 = $urandom_range(0, 1); use_rs2 = $urandom_range(0, 1);
      ex_valid = $urandom_range(0, 1); ex_rd = $urandom_range(0, 3);
      ex_is_load = $urandom_range(0, 1); ex_result = $urandom;
      mem_valid = $urandom_range(0, 1); mem_rd = $urandom_range(0, 3); mem_result = $urandom;
      wb_valid = $urandom_range(0, 1); wb_rd = $urandom_range(0, 3);
      redirect = $urandom_range(0, 6) == 0; redirect_pc = $urandom;
      mem_busy = $urandom_range(0, 3) == 0;
      cycle();
    end
    idle();
    cycle();
    cycle();
    cycle();

    mem_busy = 1;
    for (int k = 0; k < 70000; k++) cycle();
    #1;
    chk("sat_cnt", stall_cnt, 16'hFFFF);
    idle();
    cycle();
    cycle();

    redirect = 1; redirect_pc = 32'h300;
    cycle();
    idle();
    cycle();
    reset = 1;
    #1;
    chk("rst_in_flush_flush", pipe_flush, 0);
    chk("rst_in_flush_ld", ld_new_pc, 0);
    cycle();
    idle();
    #1;
    chk("after_rst_flush", pipe_flush, 0);
    chk("after_rst_ld", ld_new_pc, 0);
    chk("after_rst_cnt", stall_cnt, 0);
    cycle();
    #1;
    chk("after_rst_no_redir", ld_new_pc, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
